// File: rtl/dnn_seq.sv
// dnn_seq: control sequencer for the tiny_dnn_core array and the normalize stage.
// One start pulse runs one layer pass: INIT, EXEC over the input addresses,
// an optional BIAS step, a two-cycle DRAIN for the FMA pipeline, then OUT.
// OUT shifts N_CORE results out of the core chain through normalize using a
// valid/ready handshake.
// Optional feature macro: DNN_SEQ_PERF_EN adds the perf_cycles and perf_stall counters.
module dnn_seq #(
  parameter int F_SIZE = 1024,
  parameter int N_CORE = 16,
  localparam int AW = $clog2(F_SIZE),
  localparam int IW = $clog2(N_CORE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] n_in,
  input  logic          bias_en,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic [AW-1:0] ra,
  output logic          update,
  output logic          outr,
  output logic          norm_en,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          out_last
`ifdef DNN_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_BIAS,
    S_DRAIN,
    S_OUT
  } state_t;

  localparam logic [AW-1:0] MAX_N  = AW'(F_SIZE - 1);
  localparam logic [IW:0]   LAST_K = (IW + 1)'(N_CORE - 1);
  localparam logic [IW-1:0] TOP_IDX = IW'(N_CORE - 1);

  state_t        state;
  logic [AW-1:0] n_lat;
  logic [AW-1:0] addr;
  logic          bias_lat;
  logic          drain_cnt;
  logic [IW:0]   out_cnt;
  logic          step_ok;
  logic          last_addr;

  // Strobes and handshake outputs are decoded from the registered state; the
  // OUT step also depends on out_ready so a stalled consumer freezes the chain
  // in the same cycle.
  always_comb begin
    step_ok   = (state == S_OUT) && (out_cnt <= LAST_K) && (!out_valid || out_ready);
    last_addr = (addr == n_lat - AW'(1));
    busy      = (state != S_IDLE);
    init      = (state == S_INIT);
    exec      = (state == S_EXEC);
    bias      = (state == S_BIAS);
    ra        = (state == S_EXEC) ? addr : '0;
    outr      = step_ok;
    norm_en   = step_ok;
    update    = step_ok && (out_cnt == '0);
    done      = (state == S_OUT) && out_valid && out_ready && out_last;
  end

  // Main sequencer: walks the phases of a pass and tracks the output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      n_lat     <= '0;
      addr      <= '0;
      bias_lat  <= 1'b0;
      drain_cnt <= 1'b0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat    <= (n_in >= MAX_N) ? MAX_N : n_in;
            bias_lat <= bias_en;
            addr     <= '0;
            state    <= S_INIT;
          end
        end
        S_INIT: begin
          addr <= '0;
          if (n_lat != '0)
            state <= S_EXEC;
          else if (bias_lat)
            state <= S_BIAS;
          else
            state <= S_DRAIN;
        end
        S_EXEC: begin
          if (last_addr) begin
            addr  <= '0;
            state <= bias_lat ? S_BIAS : S_DRAIN;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        S_BIAS: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            out_cnt   <= '0;
            state     <= S_OUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_OUT: begin
          if (step_ok) begin
            out_valid <= 1'b1;
            out_idx   <= TOP_IDX - out_cnt[IW-1:0];
            out_last  <= (out_cnt == LAST_K);
            out_cnt   <= out_cnt + (IW + 1)'(1);
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DNN_SEQ_PERF_EN
  // Saturating performance counters: busy cycles and cycles the consumer stalled a valid result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == S_OUT && out_valid && !out_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dnn_seq.md
Name: dnn_seq

Overview:
Control sequencer directly upstream of the tiny_dnn_core array and the normalize stage. It issues init/exec/bias with read addresses, lets the FMA pipeline drain, then shifts accumulated results out of the core chain through normalize under a valid/ready handshake. One start pulse computes one layer pass of N_CORE neurons.

Parameters:
F_SIZE, 1024, weight memory depth per core; bias lives at F_SIZE-1; address width 10
N_CORE, 16, cores in the output shift chain; number of results per pass

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  pulse; begin a pass (ignored while busy)
n_in  in  10  input count for the pass; sampled on accepted start
bias_en  in  1  issue a bias cycle after EXEC; sampled on accepted start
out_ready  in  1  consumer accepts the normalized result
busy  out  1  pass in progress
done  out  1  one-cycle pulse: last result accepted
init  out  1  to cores: clear accumulator
exec  out  1  to cores: MAC step at address ra
bias  out  1  to cores: bias MAC step
ra  out  10  to cores and input buffer: read address
update  out  1  to cores: chain output selects own FMA result
outr  out  1  to cores: load/shift output chain
norm_en  out  1  to normalize: capture chain-end value
out_valid  out  1  normalize output holds a valid result
out_idx  out  log2(N_CORE)  core index of the current result
out_last  out  1  current result is the last of the pass

Behaviour:
- Reset: state IDLE; every output 0; internal counters 0. Reset mid-pass aborts immediately; no done.
- States: IDLE, INIT, EXEC, BIAS, DRAIN, OUT.
- IDLE: start=1 -> INIT; latch n_in (values > F_SIZE-1 clamp to F_SIZE-1) and bias_en. busy goes 1 on the next edge and stays 1 through the done cycle.
- INIT: one cycle, init=1 -> EXEC, or -> BIAS/DRAIN if latched n_in=0.
- EXEC: exec=1, ra = 0,1,...,n-1, one address per cycle, no stalls; after ra=n-1 -> BIAS if bias_en, else DRAIN.
- BIAS: one cycle, bias=1, ra=0 (core forces F_SIZE-1) -> DRAIN.
- DRAIN: exactly 2 cycles with all strobes 0. This covers the 2-cycle W1/W2 pipeline, so the final FMA write has landed. -> OUT.
- Timing with start sampled at edge 0: init in cycle 1; exec cycles 2..n+1; bias in cycle n+2 if enabled; drain over the next 2 cycles; first OUT step immediately after.
- OUT: step counter k = 0..N_CORE-1.
  - step = (!out_valid || out_ready).
  - On a step: outr=1 and norm_en=1; update=1 only when k=0 (capture), else 0.
  - Step k emits core N_CORE-1-k.
  - No step -> outr, norm_en and update all 0; the chain and normalize hold.
- out_valid: set at the edge following a step; cleared when out_valid && out_ready && no new step.
- out_idx, out_last: registered with the step. out_idx = N_CORE-1-k; out_last = (k = N_CORE-1).
- Completion: out_valid && out_ready && out_last -> done=1 for one cycle, busy=0 the next cycle, -> IDLE.
- Simultaneous start with done: the start is ignored.
- Strobes are mutually exclusive: at most one of init, exec, bias asserted per cycle.

Optional Feature:
DNN_SEQ_PERF_EN: adds outputs perf_cycles[31:0] and perf_stall[31:0].
- perf_cycles counts busy cycles; perf_stall counts OUT cycles with out_valid && !out_ready.
- Both saturate at all-ones, clear on accepted start, and hold after done.
- Without the macro the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic pass: n_in=4, bias_en=1, out_ready=1, start at cycle 0 -> init @1; exec @2-5 with ra 0,1,2,3; bias @6; outr/norm_en @9-24 (update only @9); out_idx 15..0; done @25.
- No bias, n_in=0: bias_en=0 -> init @1, no exec/bias, DRAIN @2-3, first step @4 with update=1.
- Backpressure: out_ready low for 5 cycles after the 3rd result -> outr/norm_en stay 0, out_valid and out_idx=13 held stable, perf_stall=5 (with DNN_SEQ_PERF_EN); 16 results total.
- Clamp: n_in=1023 and n_in=1023 with bias -> ra sweeps 0..1022; bias cycle follows; exec count 1023.
- Start while busy: pulse start mid-EXEC and on the done cycle -> ignored; ra sequence unchanged; single done.
- Async reset mid-OUT at k=7 -> all outputs 0 immediately, no done; a new start then runs a full correct pass.
